// File: rtl/burst_memory.sv
// rtl/burst_memory.sv - single-port burst memory with byte-enabled writes and registered read beats
module burst_memory #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = 4,
    parameter int WRAP       = 0
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  valid,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    be,
    output logic                  ready,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rvalid,
    output logic                  rlast,
    output logic                  busy,
    output logic                  err
);
    localparam int EW = ADDR_WIDTH + LEN_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                state, state_next;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] cur_addr, addr_next, mem_addr;
    logic [LEN_WIDTH-1:0]  rem, rem_next;
    logic                  mem_we, mem_re, last_beat, err_next, cmd_ok;
    logic [EW-1:0]         end_addr;

    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    assign end_addr = EW'(addr) + EW'(len);
    assign cmd_ok   = (WRAP != 0) || (end_addr <= EW'(DEPTH - 1));
    assign ready    = (state != READ) && !res;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (res) state <= IDLE;
        else     state <= state_next;
    end

    // rem counts beats still owed after the one being handled this cycle
    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = cur_addr;
        addr_next  = cur_addr;
        rem_next   = rem;
        last_beat  = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (valid) begin
                    if (!cmd_ok) begin
                        err_next = 1'b1;
                    end else begin
                        mem_we    = wr_rd;
                        mem_re    = !wr_rd;
                        mem_addr  = addr;
                        addr_next = addr_inc(addr);
                        rem_next  = len;
                        last_beat = !wr_rd && (len == '0);
                        if (len != '0) state_next = wr_rd ? WRITE : READ;
                    end
                end
            end
            WRITE: begin
                if (valid) begin
                    mem_we    = 1'b1;
                    addr_next = addr_inc(cur_addr);
                    rem_next  = rem - LEN_WIDTH'(1);
                    if (rem == LEN_WIDTH'(1)) state_next = IDLE;
                end
            end
            READ: begin
                mem_re    = 1'b1;
                addr_next = addr_inc(cur_addr);
                rem_next  = rem - LEN_WIDTH'(1);
                last_beat = (rem == LEN_WIDTH'(1));
                if (rem == LEN_WIDTH'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            cur_addr <= '0;
            rem      <= '0;
            rdata    <= '0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            err      <= 1'b0;
        end else begin
            cur_addr <= addr_next;
            rem      <= rem_next;
            rvalid   <= mem_re;
            rlast    <= last_beat;
            err      <= err_next;
            if (mem_re) rdata <= mem[mem_addr];
            if (mem_we) begin
                for (int k = 0; k < WIDTH / 8; k++) begin
                    if (be[k]) mem[mem_addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_burst_memory.sv
// tb/tb_burst_memory.sv - directed scoreboard bench for burst_memory, WRAP=0 and WRAP=1 instances
module tb_burst_memory;
    logic        clk = 1'b0;
    logic        res, valid, wr_rd;
    logic [5:0]  addr;
    logic [3:0]  len;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready0, rvalid0, rlast0, busy0, err0;
    logic        ready1, rvalid1, rlast1, busy1, err1;
    logic [31:0] rdata0, rdata1;

    logic [31:0] m0 [64];
    logic [31:0] m1 [64];
    logic [31:0] wbuf [16];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] last0, last1;
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    burst_memory #(.WIDTH(32), .DEPTH(64), .LEN_WIDTH(4), .WRAP(0)) dut0 (
        .clk(clk), .res(res), .valid(valid), .wr_rd(wr_rd), .addr(addr), .len(len),
        .wdata(wdata), .be(be), .ready(ready0), .rdata(rdata0), .rvalid(rvalid0),
        .rlast(rlast0), .busy(busy0), .err(err0));

    burst_memory #(.WIDTH(32), .DEPTH(64), .LEN_WIDTH(4), .WRAP(1)) dut1 (
        .clk(clk), .res(res), .valid(valid), .wr_rd(wr_rd), .addr(addr), .len(len),
        .wdata(wdata), .be(be), .ready(ready1), .rdata(rdata1), .rvalid(rvalid1),
        .rlast(rlast1), .busy(busy1), .err(err1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] b);
        logic [31:0] r = old;
        for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    task automatic clear_models();
        for (int i = 0; i < 64; i++) begin
            m0[i] = '0;
            m1[i] = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic wr(input int a, input int l, input logic [3:0] b, input bit gaps);
        bit ok0 = (a + l <= 63);
        for (int i = 0; i <= l; i++) begin
            if (gaps && i > 0) begin
                valid = 1'b0;
                wdata = 32'hDEAD_0000 + 32'(i);
                step();
                chk("gap_busy0", {31'b0, busy0}, 32'(ok0));
                chk("gap_busy1", {31'b0, busy1}, 32'd1);
            end
            valid = 1'b1; wr_rd = 1'b1; addr = 6'(a); len = 4'(l);
            wdata = wbuf[i]; be = b;
            step();
            if (ok0) m0[(a + i) % 64] = merge(m0[(a + i) % 64], wbuf[i], b);
            m1[(a + i) % 64] = merge(m1[(a + i) % 64], wbuf[i], b);
            if (i == 0) begin
                chk("err0", {31'b0, err0}, 32'(!ok0));
                chk("err1", {31'b0, err1}, 32'd0);
                chk("wr_busy0", {31'b0, busy0}, 32'(ok0 && l > 0));
            end
        end
        valid = 1'b0;
        chk("wr_end_busy0", {31'b0, busy0}, 32'd0);
        chk("wr_end_busy1", {31'b0, busy1}, 32'd0);
        step();
        chk("err0_cleared", {31'b0, err0}, 32'd0);
    endtask

    task automatic rd_cmd(input int a, input int l);
        for (int i = 0; i <= l; i++) begin
            q0.push_back(m0[(a + i) % 64]);
            q1.push_back(m1[(a + i) % 64]);
        end
        valid = 1'b1; wr_rd = 1'b0; addr = 6'(a); len = 4'(l);
        step();
        valid = 1'b0;
    endtask

    task automatic rd_beat(input bit is_last);
        last0 = q0.pop_front();
        last1 = q1.pop_front();
        chk("rvalid0", {31'b0, rvalid0}, 32'd1);
        chk("rdata0", rdata0, last0);
        chk("rlast0", {31'b0, rlast0}, 32'(is_last));
        chk("ready0", {31'b0, ready0}, 32'(is_last));
        chk("rdata1", rdata1, last1);
        chk("rlast1", {31'b0, rlast1}, 32'(is_last));
    endtask

    task automatic rd(input int a, input int l);
        rd_cmd(a, l);
        for (int i = 0; i <= l; i++) begin
            if (i > 0) step();
            rd_beat(i == l);
        end
        step();
        chk("rvalid0_off", {31'b0, rvalid0}, 32'd0);
        chk("rdata0_hold", rdata0, last0);
        chk("busy0_idle", {31'b0, busy0}, 32'd0);
    endtask

    initial begin
        res = 1'b1; valid = 1'b1; wr_rd = 1'b1; addr = 6'd9; len = 4'd0;
        wdata = 32'h1234_5678; be = 4'hF;
        clear_models();
        #1;
        chk("ready_in_reset", {31'b0, ready0}, 32'd0);
        step();
        step();
        chk("rst_busy", {31'b0, busy0}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid0}, 32'd0);
        chk("rst_err", {31'b0, err0}, 32'd0);
        chk("rst_rdata", rdata0, 32'd0);
        res = 1'b0;

        // first command on first edge after reset: four zero beats
        rd(0, 3);

        for (int i = 0; i < 16; i++) wbuf[i] = 32'hA0A0_0000 + 32'(i);
        wr(4, 3, 4'hF, 1'b0);
        rd(4, 3);

        wbuf[0] = 32'hFFFF_FFFF;
        wr(2, 0, 4'hF, 1'b0);
        wbuf[0] = 32'h0000_0000;
        wr(2, 0, 4'b0101, 1'b0);
        rd(2, 0);
        chk("byte_lane_const", last0, 32'hFF00_FF00);

        wbuf[0] = 32'h5555_5555;
        wr(5, 0, 4'h0, 1'b0);
        rd(5, 0);

        for (int i = 0; i < 4; i++) wbuf[i] = 32'hB000_0000 + 32'(i);
        wr(62, 3, 4'hF, 1'b0);
        rd(62, 1);
        rd(0, 1);

        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC000_00C0 + 32'(i);
        wr(10, 3, 4'hF, 1'b1);
        rd(9, 5);

        rd_cmd(4, 3);
        rd_beat(1'b0);
        step();
        rd_beat(1'b0);
        res = 1'b1;
        #1;
        chk("ready_res_mid", {31'b0, ready0}, 32'd0);
        step();
        res = 1'b0;
        chk("abort_rvalid0", {31'b0, rvalid0}, 32'd0);
        chk("abort_busy0", {31'b0, busy0}, 32'd0);
        chk("abort_rvalid1", {31'b0, rvalid1}, 32'd0);
        clear_models();
        rd(4, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/burst_memory.md
BURST_MEMORY -- requirements
Module: burst_memory

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 64, number of words.
REQ-003 Parameter ADDR_WIDTH, default $clog2(DEPTH), address width.
REQ-004 Parameter LEN_WIDTH, default 4, burst length field width.
REQ-005 Parameter WRAP, default 0; 1 = addresses wrap modulo DEPTH, 0 = out-of-range bursts are rejected.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 res  input  1  reset, synchronous and active-high.
REQ-008 valid  input  1  command or write-data beat present.
REQ-009 wr_rd  input  1  1 = write burst, 0 = read burst; sampled with the command only.
REQ-010 addr  input  ADDR_WIDTH  burst start address; sampled with the command only.
REQ-011 len  input  LEN_WIDTH  beats minus one; sampled with the command only.
REQ-012 wdata  input  WIDTH  write data for the current beat.
REQ-013 be  input  WIDTH/8  byte enables; be[k] gates wdata[8k+7:8k].
REQ-014 ready  output  1  beat accepted when valid and ready are both 1.
REQ-015 rdata  output  WIDTH  registered read data.
REQ-016 rvalid  output  1  rdata holds a valid read beat.
REQ-017 rlast  output  1  marks the final read beat of a burst.
REQ-018 busy  output  1  burst in progress (state not IDLE).
REQ-019 err  output  1  one-cycle pulse: command rejected.

Function
REQ-020 States SHALL be IDLE, WRITE and READ; ready SHALL be 1 in IDLE and WRITE, 0 in READ, and 0 while res is 1.
REQ-021 In IDLE, valid=1 SHALL accept a command (addr, len, wr_rd), plus the first write beat if wr_rd=1.
REQ-022 With WRAP=0, a command where addr+len > DEPTH-1 SHALL be rejected: err=1 the next cycle, no memory access, state stays IDLE.
REQ-023 With WRAP=1, the beat address SHALL increment modulo DEPTH (DEPTH-1 -> 0); err SHALL never assert.
REQ-024 Write command: mem[addr] SHALL be written with byte enables on the accept edge; len=0 stays IDLE, else go WRITE with len beats remaining.
REQ-025 In WRITE, each cycle with valid=1 SHALL write the next address and decrement the remaining count; valid=0 SHALL stall with no write.
REQ-026 In WRITE, wr_rd, addr and len SHALL be ignored; the last beat returns to IDLE on the same edge.
REQ-027 Byte lanes with be[k]=0 SHALL retain prior memory contents; be=0 consumes a beat without changing memory.
REQ-028 Read command: rvalid SHALL be 1 for exactly len+1 consecutive cycles, starting the cycle after acceptance, with rdata = mem[addr+i] on beat i.
REQ-029 rlast SHALL be 1 only with the final read beat; state SHALL return to IDLE so that ready=1 during the cycle rlast=1.
REQ-030 Read beats SHALL have no backpressure; valid SHALL be ignored in READ.
REQ-031 rdata SHALL hold its last value when rvalid=0.
REQ-032 busy SHALL be 1 exactly when state is WRITE or READ.

Reset
REQ-033 On a clock edge with res=1: state=IDLE, all DEPTH words cleared to 0, rdata=0, rvalid=0, rlast=0, err=0.
REQ-034 Reset SHALL have priority over every other event; it aborts any burst immediately, and no write from that cycle takes effect.
REQ-035 The first command SHALL be accepted on the first edge with res=0.

Verification
REQ-036 Reset, then read len=3 from addr 0 -> four beats of 0, rlast on the 4th, ready=0 during beats 1-3.
REQ-037 Write len=3 at addr 4 with data A0..A3 and be all-ones, then read back -> A0..A3 in order, rvalid for 4 cycles.
REQ-038 Write at addr 2 with be=4'b0101 over a word of 0xFFFFFFFF using wdata 0x00000000 -> read 0xFF00FF00.
REQ-039 WRAP=0, DEPTH=64, addr=62, len=3 -> err pulse of 1 cycle, memory unchanged, busy stays 0; with WRAP=1, the same write hits 62, 63, 0, 1.
REQ-040 Write burst with valid=0 gaps between beats -> only valid beats are written, busy stays 1 until the last beat.
REQ-041 Assert res in the middle of a read burst -> rvalid=0 the next cycle, state IDLE, a subsequent read returns 0.
